psr_cond_sequencer: RTL and testbench
=====================================

PSR_COND_SEQUENCER -- requirements
Module: psr_cond_sequencer

Interface
REQ-001 SHALL have parameter SEQ_WAIT_CYCLES, default 2, ALU execute latency in cycles (legal range 1-15).
REQ-002 SHALL have parameter SEQ_PSR, default 4, PSR flag bus width (fixed 4: bit3=N, bit2=Z, bit1=V, bit0=C).
REQ-003 SHALL have port SEQ_CLOCK_50  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port SEQ_ResetInLow_In  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port SEQ_Start_In  in  1  request to run one instruction.
REQ-006 SHALL have port SEQ_Opcode_InBus  in  4  instruction opcode.
REQ-007 SHALL have port SEQ_CondCode_InBus  in  4  branch condition field.
REQ-008 SHALL have port SEQ_Psr_InBus  in  SEQ_PSR  current flags from the PSR.
REQ-009 SHALL have port SEQ_AluOp_OutBus  out  4  ALU operation select.
REQ-010 SHALL have port SEQ_SetCodes_Out  out  1  one-cycle PSR flag-update strobe.
REQ-011 SHALL have port SEQ_RegWrite_Out  out  1  one-cycle register-file write strobe.
REQ-012 SHALL have port SEQ_PcInc_Out  out  1  one-cycle sequential PC advance.
REQ-013 SHALL have port SEQ_PcLoad_Out  out  1  one-cycle branch-target PC load.
REQ-014 SHALL have port SEQ_Busy_Out  out  1  high whenever the FSM is not in IDLE.
REQ-015 SHALL have port SEQ_Done_Out  out  1  one-cycle instruction-complete pulse.
REQ-016 SHALL have port SEQ_Error_Out  out  1  sticky illegal-opcode flag.

Function
REQ-017 SHALL implement states IDLE, DECODE, EXEC, WB, BRANCH, DONE, ERROR.
REQ-018 SHALL, in IDLE with Start=1, latch opcode and cond code, clear Error_Out, and go to DECODE; Start ignored in every other state.
REQ-019 SHALL decode in DECODE: 0x0 NOP -> DONE; 0x1-0x6 ALU, no flags -> EXEC; 0x9-0xE ALU with flags -> EXEC; 0x7 branch -> BRANCH; 0x8, 0xF illegal -> ERROR.
REQ-020 SHALL drive AluOp_OutBus = {0, opcode[2:0]} in EXEC and WB, 0x0 otherwise.
REQ-021 SHALL stay in EXEC exactly SEQ_WAIT_CYCLES cycles (down-counter loaded on DECODE exit), then go to WB.
REQ-022 SHALL assert RegWrite_Out for the single WB cycle, and SetCodes_Out in that same cycle only when opcode[3]=1; WB -> DONE.
REQ-023 SHALL sample Psr_InBus in BRANCH (never at Start), so flags written by the preceding instruction's WB are used.
REQ-024 SHALL evaluate base condition on cond[2:0]: 0 false, 1 Z, 2 Z|(N^V), 3 N^V, 4 C|Z, 5 C, 6 N, 7 V; taken = base XOR cond[3]; register result; BRANCH -> DONE.
REQ-025 SHALL, in DONE, pulse Done_Out and exactly one of PcLoad_Out (taken branch) or PcInc_Out (all else); DONE -> IDLE.
REQ-026 SHALL, in ERROR, set Error_Out, assert no strobe, and return to IDLE next cycle; Error_Out holds until the next accepted Start or reset.
REQ-027 SHALL give latencies from the Start-sampling edge: NOP Done at +2, branch Done at +3, ALU Done at +3+SEQ_WAIT_CYCLES.
REQ-028 SHALL never assert SetCodes_Out, RegWrite_Out, PcInc_Out or PcLoad_Out outside the states above.
REQ-029 SHALL treat a Start held high through DONE as a new request, accepted in the IDLE cycle following DONE.

Reset
REQ-030 SHALL, on ResetInLow=0, immediately force IDLE, counter 0, latched opcode/cond 0, and all outputs 0 (AluOp 0x0), regardless of state.
REQ-031 SHALL abort an in-flight instruction on reset mid-operation with no strobe emitted; operation resumes on the first clock edge after release.

Verification
REQ-032 SHALL cover: opcode 0x9, WAIT=2, Start pulse -> AluOp 0x1 for 3 cycles, RegWrite+SetCodes together at +4, Done+PcInc at +5.
REQ-033 SHALL cover: opcode 0x2 -> RegWrite at WB, SetCodes stays 0 throughout.
REQ-034 SHALL cover: opcode 0x7, cond 0x1, PSR=0100 -> PcLoad at +3; same with PSR=0000 -> PcInc at +3; cond 0x8 -> always PcLoad, cond 0x0 -> always PcInc.
REQ-035 SHALL cover: cond 0xB (GE), PSR N=1,V=1 -> taken; PSR N=1,V=0 -> not taken.
REQ-036 SHALL cover: opcode 0xF -> Error_Out=1 at +2, no strobes, Busy drops at +3; next Start with 0x0 clears Error_Out.
REQ-037 SHALL cover: reset asserted during EXEC -> all outputs 0 asynchronously, no WB strobe, Start after release runs normally.

Source files
------------

// File: rtl/psr_cond_sequencer.sv
// -----------------------------------------------------------------------------
// psr_cond_sequencer
//
// Purpose:
//   Multi-cycle instruction sequencer for a small ALU datapath. It accepts one
//   instruction per Start request and walks it through decode, ALU execute,
//   write-back or conditional branch evaluation. It then emits a single PC
//   update and a completion pulse. Illegal opcodes raise a sticky error flag.
//
//   Every output is a registered function of the current FSM state. As a
//   result, each strobe appears one clock after the FSM enters the state
//   that owns it. Measured from the edge that samples Start:
//     NOP    -> Done at +2
//     branch -> Done at +3
//     ALU    -> Done at +3+SEQ_WAIT_CYCLES
//
// Parameters:
//   SEQ_WAIT_CYCLES : ALU execute latency in cycles (1..15)
//   SEQ_PSR         : PSR flag bus width, fixed at 4 (N,Z,V,C from bit3 down)
//
// Ports:
//   SEQ_CLOCK_50        in   single rising-edge clock
//   SEQ_ResetInLow_In   in   asynchronous active-low reset
//   SEQ_Start_In        in   request to run one instruction (sampled in IDLE)
//   SEQ_Opcode_InBus    in   [3:0] instruction opcode
//   SEQ_CondCode_InBus  in   [3:0] branch condition field
//   SEQ_Psr_InBus       in   [SEQ_PSR-1:0] current PSR flags
//   SEQ_AluOp_OutBus    out  [3:0] ALU operation select (EXEC/WB only)
//   SEQ_SetCodes_Out    out  one-cycle PSR flag-update strobe
//   SEQ_RegWrite_Out    out  one-cycle register-file write strobe
//   SEQ_PcInc_Out       out  one-cycle sequential PC advance
//   SEQ_PcLoad_Out      out  one-cycle branch-target PC load
//   SEQ_Busy_Out        out  high while an instruction is in flight
//   SEQ_Done_Out        out  one-cycle instruction-complete pulse
//   SEQ_Error_Out       out  sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module psr_cond_sequencer #(
  parameter int unsigned SEQ_WAIT_CYCLES = 2,
  parameter int unsigned SEQ_PSR         = 4
) (
  input  logic               SEQ_CLOCK_50,
  input  logic               SEQ_ResetInLow_In,
  input  logic               SEQ_Start_In,
  input  logic [3:0]         SEQ_Opcode_InBus,
  input  logic [3:0]         SEQ_CondCode_InBus,
  input  logic [SEQ_PSR-1:0] SEQ_Psr_InBus,
  output logic [3:0]         SEQ_AluOp_OutBus,
  output logic               SEQ_SetCodes_Out,
  output logic               SEQ_RegWrite_Out,
  output logic               SEQ_PcInc_Out,
  output logic               SEQ_PcLoad_Out,
  output logic               SEQ_Busy_Out,
  output logic               SEQ_Done_Out,
  output logic               SEQ_Error_Out
);

  // Execute down-counter reload value.
  localparam logic [3:0] WAIT_LOAD = 4'(SEQ_WAIT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_BRANCH = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } seq_state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Opcode class -> state that follows DECODE.
  function automatic seq_state_e decode_next(input logic [3:0] op);
    seq_state_e nxt;
    case (op)
      4'h0:        nxt = ST_DONE;    // NOP
      4'h7:        nxt = ST_BRANCH;  // conditional branch
      4'h8, 4'hF:  nxt = ST_ERROR;   // illegal
      default:     nxt = ST_EXEC;    // 0x1-0x6 and 0x9-0xE are ALU ops
    endcase
    return nxt;
  endfunction

  // Branch condition evaluation. cond[3] inverts the base test, which gives
  // each base condition its complement (e.g. 0x0 never, 0x8 always).
  function automatic logic cond_taken(input logic [3:0] cond,
                                      input logic [3:0] psr);
    logic n_f;
    logic z_f;
    logic v_f;
    logic c_f;
    logic base;
    n_f = psr[3];
    z_f = psr[2];
    v_f = psr[1];
    c_f = psr[0];
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z_f;
      3'd2:    base = z_f | (n_f ^ v_f);
      3'd3:    base = n_f ^ v_f;
      3'd4:    base = c_f | z_f;
      3'd5:    base = c_f;
      3'd6:    base = n_f;
      3'd7:    base = v_f;
      default: base = 1'b0;
    endcase
    return base ^ cond[3];
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  seq_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [3:0] cond_q, cond_d;
  logic       taken_q, taken_d;

  // Registered outputs
  logic [3:0] alu_q, alu_d;
  logic       setc_q, setc_d;
  logic       regw_q, regw_d;
  logic       pcinc_q, pcinc_d;
  logic       pcload_q, pcload_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // Next-state logic: sequencing, instruction latch, execute counter, branch
  // decision and the sticky error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    cond_d  = cond_q;
    taken_d = taken_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (SEQ_Start_In) begin
          op_d    = SEQ_Opcode_InBus;
          cond_d  = SEQ_CondCode_InBus;
          err_d   = 1'b0;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DECODE: begin
        // Clear any stale branch result so that non-branch instructions
        // always finish with a sequential PC advance.
        taken_d = 1'b0;
        state_d = decode_next(op_q);
        if (decode_next(op_q) == ST_EXEC) begin
          cnt_d = WAIT_LOAD;
        end else begin
          cnt_d = 4'd0;
        end
      end

      ST_EXEC: begin
        // The count of 1 marks the final execute cycle. The <= test also
        // covers an out-of-range zero load, so EXEC can never stall.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_WB;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_EXEC;
        end
      end

      ST_WB: begin
        state_d = ST_DONE;
      end

      ST_BRANCH: begin
        // Flags are sampled here rather than at Start. This picks up a PSR
        // update from the previous instruction's write-back.
        taken_d = cond_taken(cond_q, SEQ_Psr_InBus[3:0]);
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: each output is a function of the current state, and the
  // result is registered below.
  always_comb begin
    alu_d    = 4'h0;
    setc_d   = 1'b0;
    regw_d   = 1'b0;
    pcinc_d  = 1'b0;
    pcload_d = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
      end

      ST_EXEC: begin
        alu_d = {1'b0, op_q[2:0]};
      end

      ST_WB: begin
        alu_d  = {1'b0, op_q[2:0]};
        regw_d = 1'b1;
        setc_d = op_q[3];
      end

      ST_DONE: begin
        done_d   = 1'b1;
        pcload_d = taken_q;
        pcinc_d  = ~taken_q;
      end

      ST_DECODE, ST_BRANCH, ST_ERROR: begin
        busy_d = 1'b1;
      end

      default: begin
        busy_d = 1'b1;
      end
    endcase
  end

  // State, instruction latch and counter registers.
  always_ff @(posedge SEQ_CLOCK_50 or negedge SEQ_ResetInLow_In) begin
    if (!SEQ_ResetInLow_In) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'h0;
      cond_q  <= 4'h0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
    end
  end

  // Output registers. Reset clears every output immediately, which also drops
  // any strobe belonging to an aborted instruction.
  always_ff @(posedge SEQ_CLOCK_50 or negedge SEQ_ResetInLow_In) begin
    if (!SEQ_ResetInLow_In) begin
      alu_q    <= 4'h0;
      setc_q   <= 1'b0;
      regw_q   <= 1'b0;
      pcinc_q  <= 1'b0;
      pcload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      alu_q    <= alu_d;
      setc_q   <= setc_d;
      regw_q   <= regw_d;
      pcinc_q  <= pcinc_d;
      pcload_q <= pcload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign SEQ_AluOp_OutBus = alu_q;
  assign SEQ_SetCodes_Out = setc_q;
  assign SEQ_RegWrite_Out = regw_q;
  assign SEQ_PcInc_Out    = pcinc_q;
  assign SEQ_PcLoad_Out   = pcload_q;
  assign SEQ_Busy_Out     = busy_q;
  assign SEQ_Done_Out     = done_q;
  assign SEQ_Error_Out    = err_q;

endmodule

// File: tb/tb_psr_cond_sequencer.sv
// -----------------------------------------------------------------------------
// tb_psr_cond_sequencer
//
// Directed testbench for psr_cond_sequencer. The expected output word for each
// cycle after the Start-sampling edge comes from the documented latency
// behaviour of each instruction class. Each branch vector carries a
// hand-computed taken/not-taken value.
// -----------------------------------------------------------------------------
module tb_psr_cond_sequencer;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] op;
  logic [3:0] cond;
  logic [3:0] psr;

  logic [3:0] alu_o;
  logic       setc_o;
  logic       regw_o;
  logic       pcinc_o;
  logic       pcload_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  logic [10:0] obs_w;

  int vectors_applied = 0;
  int miscompares     = 0;

  psr_cond_sequencer #(
    .SEQ_WAIT_CYCLES(W),
    .SEQ_PSR        (4)
  ) dut (
    .SEQ_CLOCK_50      (clk),
    .SEQ_ResetInLow_In (rst_n),
    .SEQ_Start_In      (start),
    .SEQ_Opcode_InBus  (op),
    .SEQ_CondCode_InBus(cond),
    .SEQ_Psr_InBus     (psr),
    .SEQ_AluOp_OutBus  (alu_o),
    .SEQ_SetCodes_Out  (setc_o),
    .SEQ_RegWrite_Out  (regw_o),
    .SEQ_PcInc_Out     (pcinc_o),
    .SEQ_PcLoad_Out    (pcload_o),
    .SEQ_Busy_Out      (busy_o),
    .SEQ_Done_Out      (done_o),
    .SEQ_Error_Out     (err_o)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  // Output word layout: {alu[3:0], setc, regw, pcinc, pcload, busy, done, err}
  assign obs_w = {alu_o, setc_o, regw_o, pcinc_o, pcload_o, busy_o, done_o, err_o};

  task automatic check_vec(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  // Expected output word k cycles after the Start-sampling edge.
  function automatic logic [10:0] expect_out(input int k, input logic [3:0] o, input logic tk);
    logic [3:0] a;
    logic sc, rw, inc, ld, bsy, dn, er;
    a = 4'h0; sc = 1'b0; rw = 1'b0; inc = 1'b0; ld = 1'b0; bsy = 1'b0; dn = 1'b0; er = 1'b0;
    if (o == 4'h0) begin
      bsy = (k >= 1 && k <= 2);
      dn  = (k == 2);
      inc = dn;
    end else if (o == 4'h7) begin
      bsy = (k >= 1 && k <= 3);
      dn  = (k == 3);
      ld  = dn && tk;
      inc = dn && !tk;
    end else if (o == 4'h8 || o == 4'hF) begin
      bsy = (k >= 1 && k <= 2);
      er  = (k >= 2);
    end else begin
      a   = (k >= 2 && k <= W + 2) ? {1'b0, o[2:0]} : 4'h0;
      rw  = (k == W + 2);
      sc  = rw && o[3];
      bsy = (k >= 1 && k <= W + 3);
      dn  = (k == W + 3);
      inc = dn;
    end
    return {a, sc, rw, inc, ld, bsy, dn, er};
  endfunction

  // Issue one instruction with a single-cycle Start pulse and check 8 cycles.
  task automatic run_instr(input logic [3:0] o, input logic [3:0] c, input logic [3:0] p,
                           input logic tk, input string name);
    @(negedge clk);
    op    = o;
    cond  = c;
    psr   = p;
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      check_vec($sformatf("%s_k%0d", name, k), obs_w, expect_out(k, o, tk));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 4'h0;
    cond  = 4'h0;
    psr   = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("reset_state", obs_w, 11'h000);
    rst_n = 1'b1;

    // ALU and branch vectors (expected taken values computed by hand)
    run_instr(4'h9, 4'h0, 4'b0000, 1'b0, "alu9_flags");
    run_instr(4'h2, 4'h0, 4'b0000, 1'b0, "alu2_noflags");
    run_instr(4'h7, 4'h1, 4'b0100, 1'b1, "beq_taken");
    run_instr(4'h7, 4'h1, 4'b0000, 1'b0, "beq_not");
    run_instr(4'h7, 4'h8, 4'b0000, 1'b1, "b_always");
    run_instr(4'h7, 4'h0, 4'b1111, 1'b0, "b_never");
    run_instr(4'h7, 4'hB, 4'b1010, 1'b1, "bge_taken");
    run_instr(4'h7, 4'hB, 4'b1000, 1'b0, "bge_not");
    run_instr(4'h7, 4'h2, 4'b0010, 1'b1, "ble_nv");
    run_instr(4'h7, 4'h4, 4'b0001, 1'b1, "bcz_c");
    run_instr(4'h7, 4'hE, 4'b1000, 1'b0, "bnn_not");
    run_instr(4'h7, 4'h5, 4'b0001, 1'b1, "bc_taken");
    run_instr(4'h7, 4'h7, 4'b0000, 1'b0, "bv_not");
    run_instr(4'h9, 4'h0, 4'b0000, 1'b0, "alu_after_br");

    // Illegal opcodes, sticky error and clearing by the next accepted Start
    run_instr(4'hF, 4'h0, 4'b0000, 1'b0, "illegal_F");
    run_instr(4'h0, 4'h0, 4'b0000, 1'b0, "nop_clr_err");
    run_instr(4'h8, 4'h0, 4'b0000, 1'b0, "illegal_8");
    run_instr(4'hE, 4'h0, 4'b0000, 1'b0, "aluE_clr_err");

    // Start held high: back-to-back NOPs complete at +2 and +5
    @(negedge clk);
    op    = 4'h0;
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_vec($sformatf("held_start_done_k%0d", k), {10'd0, done_o},
                {10'd0, (k == 2 || k == 5) ? 1'b1 : 1'b0});
      if (k == 5) start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_vec("held_start_idle", obs_w, 11'h000);

    // Reset in the middle of EXEC aborts the instruction
    @(negedge clk);
    op    = 4'h9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_vec("rst_pre_alu", {7'd0, alu_o}, 11'h001);
    #3 rst_n = 1'b0;
    #1 check_vec("rst_async_clear", obs_w, 11'h000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_vec($sformatf("rst_hold_k%0d", k), obs_w, 11'h000);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_vec($sformatf("rst_release_idle_k%0d", k), obs_w, 11'h000);
    end
    run_instr(4'h9, 4'h0, 4'b0000, 1'b0, "post_reset_alu9");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
